// File: rtl/sig_crc_check.sv
// SIGNAL field receiver: deserialises voted bits, checks the CRC-16 over the payload
// and reports the parallel payload with a pass/fail flag plus debug counters.
module sig_crc_check #(
  parameter int FRAME_BITS = 96,
  parameter int CRC_W = 16,
  parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021,
  parameter logic [CRC_W-1:0] CRC_INIT = 16'hFFFF,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        di,
  input  logic                        di_vld,
  output logic [FRAME_BITS-CRC_W-1:0] payload,
  output logic                        crc_ok,
  output logic                        frame_vld,
  output logic                        timeout_err,
  output logic [15:0]                 frame_cnt,
  output logic [15:0]                 err_cnt
);

  localparam int PAY_W = FRAME_BITS - CRC_W;
  localparam int BW = $clog2(FRAME_BITS) + 1;
  localparam int GW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, PAY, RXCRC, REPORT} state_t;

  state_t           state;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] rx_crc;
  logic [PAY_W-1:0] shadow;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             crc_match;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // The final CRC bit is still on di when the compare is made.
  assign crc_match = (crc == {rx_crc[CRC_W-2:0], di});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      crc         <= CRC_INIT;
      rx_crc      <= '0;
      shadow      <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      payload     <= '0;
      crc_ok      <= 1'b0;
      frame_vld   <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_vld   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (di_vld) begin
            shadow  <= {shadow[PAY_W-2:0], di};
            crc     <= crc_step(CRC_INIT, di);
            bit_cnt <= BW'(1);
            state   <= PAY;
          end
        end
        PAY, RXCRC: begin
          if (di_vld) begin
            gap_cnt <= '0;
            if (state == PAY) begin
              shadow <= {shadow[PAY_W-2:0], di};
              crc    <= crc_step(crc, di);
              if (bit_cnt == BW'(PAY_W - 1)) begin
                bit_cnt <= '0;
                state   <= RXCRC;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              rx_crc <= {rx_crc[CRC_W-2:0], di};
              if (bit_cnt == BW'(CRC_W - 1)) begin
                // Results are registered here so they are visible during REPORT.
                bit_cnt   <= '0;
                payload   <= shadow;
                crc_ok    <= crc_match;
                frame_vld <= 1'b1;
                if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                if (!crc_match && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                state     <= REPORT;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end else if (gap_cnt == GW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            crc     <= CRC_INIT;
            bit_cnt <= '0;
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        REPORT: begin
          gap_cnt <= '0;
          if (di_vld) begin
            shadow  <= {shadow[PAY_W-2:0], di};
            crc     <= crc_step(CRC_INIT, di);
            bit_cnt <= BW'(1);
            state   <= PAY;
          end else begin
            crc     <= CRC_INIT;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sig_crc_check.sv
// Directed bench for sig_crc_check: known-answer CRC, corrupted CRC, back-to-back,
// gaps/timeout, mid-frame reset and counter saturation.
module tb_sig_crc_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        di, di_vld, di88, di_vld88;
  logic [79:0] payload;
  logic        crc_ok, frame_vld, timeout_err;
  logic [15:0] frame_cnt, err_cnt;
  logic [71:0] payload88;
  logic        crc_ok88, frame_vld88, timeout_err88;
  logic [15:0] frame_cnt88, err_cnt88;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_pulses = 0;
  int to_pulses = 0;
  int vld_cyc[$];

  always #5 clk = ~clk;

  sig_crc_check dut (
    .clk(clk), .rst(rst), .di(di), .di_vld(di_vld),
    .payload(payload), .crc_ok(crc_ok), .frame_vld(frame_vld),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  sig_crc_check #(.FRAME_BITS(88)) dut88 (
    .clk(clk), .rst(rst), .di(di88), .di_vld(di_vld88),
    .payload(payload88), .crc_ok(crc_ok88), .frame_vld(frame_vld88),
    .timeout_err(timeout_err88), .frame_cnt(frame_cnt88), .err_cnt(err_cnt88)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_vld === 1'b1) begin
      vld_pulses++;
      vld_cyc.push_back(cyc);
    end
    if (timeout_err === 1'b1) to_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-16/CCITT-FALSE over an 80-bit payload, MSB first.
  function automatic logic [15:0] crc_model(input logic [79:0] d);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 79; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Drives the first 'count' bits of a 'width'-bit frame; gap<0 means gaps of 1..63.
  task automatic applyStimulus(input logic [95:0] frame, input int width, input int count,
                               input int gap, input bit to88);
    int g;
    for (int i = 0; i < count; i++) begin
      if (to88) begin
        di88 = frame[width-1-i];
        di_vld88 = 1'b1;
      end else begin
        di = frame[width-1-i];
        di_vld = 1'b1;
      end
      @(negedge clk);
      if (gap != 0 && i < count - 1) begin
        di_vld = 1'b0;
        di_vld88 = 1'b0;
        g = (gap < 0) ? (i % 63) + 1 : gap;
        repeat (g) @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    di_vld = 1'b0;
    di_vld88 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [79:0] rand_payload();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [79:0] p1, p2, p3;
    logic [15:0] c1;
    int base_v, base_t;

    rst = 1'b1; di = 1'b0; di_vld = 1'b0; di88 = 1'b0; di_vld88 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_payload", 96'(payload), 96'h0);
    checkOutput("rst_crc_ok", 96'(crc_ok), 96'h0);
    checkOutput("rst_frame_vld", 96'(frame_vld), 96'h0);
    checkOutput("rst_timeout", 96'(timeout_err), 96'h0);
    checkOutput("rst_frame_cnt", 96'(frame_cnt), 96'h0);
    checkOutput("rst_err_cnt", 96'(err_cnt), 96'h0);
    rst = 1'b0;
    @(negedge clk);

    // Known answer: "123456789" with CRC 0x29B1
    applyStimulus({8'h00, 72'h313233343536373839, 16'h29B1}, 88, 88, 0, 1'b1);
    checkOutput("t1_vld", 96'(frame_vld88), 96'h1);
    checkOutput("t1_payload", 96'(payload88), 96'h313233343536373839);
    checkOutput("t1_crc_ok", 96'(crc_ok88), 96'h1);
    idle(1);
    checkOutput("t1_vld_pulse", 96'(frame_vld88), 96'h0);
    checkOutput("t1_frame_cnt", 96'(frame_cnt88), 96'h1);

    // Good CRC then one flipped CRC bit
    p1 = rand_payload();
    c1 = crc_model(p1);
    applyStimulus({p1, c1}, 96, 96, 0, 1'b0);
    checkOutput("t2_vld", 96'(frame_vld), 96'h1);
    checkOutput("t2_payload", 96'(payload), 96'(p1));
    checkOutput("t2_crc_ok", 96'(crc_ok), 96'h1);
    idle(2);
    applyStimulus({p1, c1 ^ 16'h0004}, 96, 96, 0, 1'b0);
    checkOutput("t2_bad_vld", 96'(frame_vld), 96'h1);
    checkOutput("t2_bad_crc_ok", 96'(crc_ok), 96'h0);
    idle(1);
    checkOutput("t2_err_cnt", 96'(err_cnt), 96'h1);
    checkOutput("t2_frame_cnt", 96'(frame_cnt), 96'h2);
    checkOutput("t2_crc_ok_hold", 96'(crc_ok), 96'h0);

    // Back-to-back with di_vld held through REPORT
    idle(2);
    base_v = vld_pulses;
    p1 = rand_payload();
    p2 = rand_payload();
    applyStimulus({p1, crc_model(p1)}, 96, 96, 0, 1'b0);
    checkOutput("t3_vld1", 96'(frame_vld), 96'h1);
    checkOutput("t3_payload1", 96'(payload), 96'(p1));
    checkOutput("t3_crc_ok1", 96'(crc_ok), 96'h1);
    applyStimulus({p2, crc_model(p2)}, 96, 96, 0, 1'b0);
    checkOutput("t3_vld2", 96'(frame_vld), 96'h1);
    checkOutput("t3_payload2", 96'(payload), 96'(p2));
    checkOutput("t3_crc_ok2", 96'(crc_ok), 96'h1);
    idle(2);
    checkOutput("t3_pulses", 96'(vld_pulses - base_v), 96'd2);
    if (vld_cyc.size() >= 2)
      checkOutput("t3_spacing", 96'(vld_cyc[vld_cyc.size()-1] - vld_cyc[vld_cyc.size()-2]), 96'd96);
    checkOutput("t3_frame_cnt", 96'(frame_cnt), 96'h4);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Gaps of 1..63 are tolerated, a gap of 64 aborts
    p1 = rand_payload();
    applyStimulus({p1, crc_model(p1)}, 96, 96, -1, 1'b0);
    checkOutput("t4_gap_vld", 96'(frame_vld), 96'h1);
    checkOutput("t4_gap_crc_ok", 96'(crc_ok), 96'h1);
    idle(2);
    base_v = vld_pulses;
    base_t = to_pulses;
    p2 = rand_payload();
    applyStimulus({p2, crc_model(p2)}, 96, 41, 0, 1'b0);
    idle(63);
    checkOutput("t4_no_timeout_63", 96'(timeout_err), 96'h0);
    @(negedge clk);
    checkOutput("t4_timeout", 96'(timeout_err), 96'h1);
    checkOutput("t4_err_cnt", 96'(err_cnt), 96'h1);
    @(negedge clk);
    checkOutput("t4_timeout_pulse", 96'(timeout_err), 96'h0);
    checkOutput("t4_to_pulses", 96'(to_pulses - base_t), 96'd1);
    checkOutput("t4_no_frame", 96'(vld_pulses - base_v), 96'd0);
    checkOutput("t4_payload_kept", 96'(payload), 96'(p1));
    checkOutput("t4_frame_cnt", 96'(frame_cnt), 96'h1);
    p3 = rand_payload();
    applyStimulus({p3, crc_model(p3)}, 96, 96, 0, 1'b0);
    checkOutput("t4_clean_ok", 96'(crc_ok), 96'h1);
    checkOutput("t4_clean_payload", 96'(payload), 96'(p3));
    idle(1);
    checkOutput("t4_clean_cnt", 96'(frame_cnt), 96'h2);

    // Asynchronous reset mid-frame
    p1 = rand_payload();
    applyStimulus({p1, crc_model(p1)}, 96, 50, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_frame_cnt", 96'(frame_cnt), 96'h0);
    checkOutput("t5_err_cnt", 96'(err_cnt), 96'h0);
    checkOutput("t5_payload", 96'(payload), 96'h0);
    checkOutput("t5_crc_ok", 96'(crc_ok), 96'h0);
    di_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    p2 = rand_payload();
    applyStimulus({p2, crc_model(p2)}, 96, 96, 0, 1'b0);
    checkOutput("t5_next_ok", 96'(crc_ok), 96'h1);
    checkOutput("t5_next_payload", 96'(payload), 96'(p2));
    idle(1);
    checkOutput("t5_next_cnt", 96'(frame_cnt), 96'h1);

    // Saturation of frame_cnt
    force dut.frame_cnt = 16'hFFFD;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    checkOutput("t6_deposit", 96'(frame_cnt), 96'hFFFD);
    for (int k = 0; k < 3; k++) begin
      p1 = rand_payload();
      applyStimulus({p1, crc_model(p1)}, 96, 96, 0, 1'b0);
      checkOutput("t6_crc_ok", 96'(crc_ok), 96'h1);
      idle(1);
      checkOutput("t6_frame_cnt", 96'(frame_cnt), (k == 0) ? 96'hFFFE : 96'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
